// File: rtl/decod_sched_pkg.sv
// Shared types and helpers for the decoder round-robin scheduler.
// Imported by the picker and the scheduler top.
package decod_sched_pkg;

  localparam int IDX_W = 4;
  localparam int N_REQ = 2 ** IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // (idx + 1) mod N_REQ; wraps naturally at IDX_W bits
  function automatic logic [IDX_W-1:0] next_ptr(
    input logic [IDX_W-1:0] idx
  );
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/decod_rr_sched_pick.sv
// Masked priority encoder: lowest set req bit at or above ptr,
// falling back to the lowest set bit overall (wrap 15 -> 0).
module rr_prio_pick
  import decod_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  assign mask   = {N_REQ{1'b1}} << ptr;
  assign masked = req & mask;
  assign any    = |req;

  // Two searches; the masked one wins whenever it finds anything
  always_comb begin
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (masked[i]) idx_hi = IDX_W'(i);
      if (req[i])    idx_lo = IDX_W'(i);
    end
    idx = (|masked) ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/decod_rr_sched.sv
// Round-robin owner scheduler driving a 16-way one-hot decoder,
// with hold timeout and a forced idle cycle between owners.
module decod_rr_sched
  import decod_sched_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_en,
  output logic [IDX_W-1:0] gnt_sel,
  output logic             busy,
  output logic             preempt
);

  localparam int HW =
    (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic TO_EN = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nx;
  logic [IDX_W-1:0] sel_nx;
  logic [HW-1:0]    hold;
  logic [HW-1:0]    hold_nx;
  logic             en_nx;
  logic             pre_nx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             own_req;
  logic             timeout;

  rr_prio_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_req = req[gnt_sel];
  assign timeout = TO_EN && (hold == HOLD_MAX);
  assign busy    = gnt_en;

  // Next-state and next-output decode; release beats timeout
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = gnt_sel;
    hold_nx  = hold;
    en_nx    = 1'b0;
    pre_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = GRANT;
          sel_nx   = pick_idx;
          hold_nx  = HOLD_ONE;
          ptr_nx   = next_ptr(pick_idx);
          en_nx    = 1'b1;
        end
      end
      GRANT: begin
        if (!own_req) begin
          state_nx = IDLE;
        end else if (timeout) begin
          state_nx = IDLE;
          pre_nx   = 1'b1;
        end else begin
          en_nx = 1'b1;
          if (hold != {HW{1'b1}}) hold_nx = hold + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      hold    <= '0;
      gnt_sel <= '0;
      gnt_en  <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      hold    <= hold_nx;
      gnt_sel <= sel_nx;
      gnt_en  <= en_nx;
      preempt <= pre_nx;
    end
  end

endmodule
